// File: rtl/fsm_mascota_pkg.sv
// Shared types and constants for the virtual-pet core: mood codes, need indices,
// level limits and small pure helpers used by the mood/selection logic.
package fsm_mascota_pkg;

  typedef enum logic [2:0] {
    MOOD_IDLE   = 3'd0,
    MOOD_HUNGRY = 3'd1,
    MOOD_TIRED  = 3'd2,
    MOOD_SAD    = 3'd3,
    MOOD_SICK   = 3'd4,
    MOOD_DEAD   = 3'd5
  } mood_t;

  localparam int NEED_COUNT = 4;

  localparam logic [1:0] HUNGER = 2'd0;
  localparam logic [1:0] ENERGY = 2'd1;
  localparam logic [1:0] FUN    = 2'd2;
  localparam logic [1:0] HEALTH = 2'd3;

  localparam logic [2:0] LEVEL_MAX   = 3'd7;
  localparam logic [2:0] LEVEL_RESET = 3'd7;
  localparam logic [2:0] LEVEL_ALERT = 3'd1;

  typedef logic [2:0] level_t;
  typedef level_t [NEED_COUNT-1:0] levels_t;

  // Forced-mood cycle used by the bring-up mode; DEAD never appears in it.
  function automatic mood_t next_forced_mood(input mood_t m);
    case (m)
      MOOD_IDLE:   return MOOD_HUNGRY;
      MOOD_HUNGRY: return MOOD_TIRED;
      MOOD_TIRED:  return MOOD_SAD;
      MOOD_SAD:    return MOOD_SICK;
      default:     return MOOD_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] sel_for_mood(input mood_t m);
    case (m)
      MOOD_TIRED: return ENERGY;
      MOOD_SAD:   return FUN;
      MOOD_SICK:  return HEALTH;
      default:    return HUNGER;
    endcase
  endfunction

  function automatic level_t clamp_level(input int v);
    if (v < 0) return 3'd0;
    if (v > int'(LEVEL_MAX)) return LEVEL_MAX;
    return level_t'(v);
  endfunction

  // Health outranks hunger, which outranks energy, which outranks fun.
  function automatic mood_t mood_from_levels(input levels_t l);
    if (l[HEALTH] <= LEVEL_ALERT) return MOOD_SICK;
    if (l[HUNGER] <= LEVEL_ALERT) return MOOD_HUNGRY;
    if (l[ENERGY] <= LEVEL_ALERT) return MOOD_TIRED;
    if (l[FUN] <= LEVEL_ALERT) return MOOD_SAD;
    return MOOD_IDLE;
  endfunction

endpackage

// File: rtl/mascota_tick_gen.sv
// Decay tick generator: period BASE_TICK << (2*time_control), frozen by 'freeze',
// restarted from zero whenever time_control changes.
module mascota_tick_gen #(
  parameter int BASE_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] time_control,
  input  logic       freeze,
  output logic       tick
);

  localparam int MAX_PERIOD = BASE_TICK << 6;
  localparam int CNT_W      = $clog2(MAX_PERIOD);

  localparam logic [CNT_W-1:0] LAST_0 = CNT_W'(BASE_TICK - 1);
  localparam logic [CNT_W-1:0] LAST_1 = CNT_W'((BASE_TICK << 2) - 1);
  localparam logic [CNT_W-1:0] LAST_2 = CNT_W'((BASE_TICK << 4) - 1);
  localparam logic [CNT_W-1:0] LAST_3 = CNT_W'((BASE_TICK << 6) - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_count;
  logic [1:0]       tc_q;
  logic             tc_changed;

  always_comb begin
    case (time_control)
      2'd0:    last_count = LAST_0;
      2'd1:    last_count = LAST_1;
      2'd2:    last_count = LAST_2;
      default: last_count = LAST_3;
    endcase
  end

  assign tc_changed = (time_control != tc_q);
  assign tick       = !freeze && !tc_changed && (cnt_q == last_count);

  // A period change restarts the count even while frozen, so the new
  // period always starts from a clean zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= time_control;
    end else begin
      tc_q <= time_control;
      if (tc_changed) begin
        cnt_q <= '0;
      end else if (!freeze) begin
        if (cnt_q == last_count) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_mascota.sv
// Virtual-pet core: need levels, decay, care actions, mood and display/alert outputs.
// Optional feature macro FSM_MASCOTA_DEATH_EN adds an absorbing DEAD mood at health 0.
module fsm_mascota
  import fsm_mascota_pkg::*;
#(
  parameter int BASE_TICK = 16,
  parameter int CARE_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       test,
  input  logic [1:0] color,
  input  logic [1:0] time_control,
  output logic [7:0] output1,
  output logic [3:0] output2
);

  levels_t    levels_q, levels_d;
  logic [1:0] sel_q, sel_d;
  logic       sleep_q, sleep_d;
  mood_t      mood_q, mood_d, test_mood_q, test_mood_d;
  logic       phase_q, phase_d;
  logic [1:0] color_q;
  logic       a_q, b_q, c_q;
  logic       a_rise, b_rise, c_rise;
  logic       dead, tick;
  logic [1:0] care_idx;
  level_t     selected_level;
  logic [3:0] alerts_d;
  int         delta [NEED_COUNT];

  assign a_rise = A && !a_q;
  assign b_rise = B && !b_q;
  assign c_rise = C && !c_q;

`ifdef FSM_MASCOTA_DEATH_EN
  assign dead = (mood_q == MOOD_DEAD);
`else
  assign dead = 1'b0;
`endif

  mascota_tick_gen #(.BASE_TICK(BASE_TICK)) u_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .time_control (time_control),
    .freeze       (test || dead),
    .tick         (tick)
  );

  // Next-state: DEAD holds everything, test mode forces mood/levels by hand,
  // normal mode folds tick decay and care into one saturating update.
  always_comb begin
    levels_d    = levels_q;
    sel_d       = sel_q;
    sleep_d     = sleep_q;
    mood_d      = mood_q;
    test_mood_d = test_mood_q;
    phase_d     = phase_q;
    care_idx    = sel_q;
    for (int i = 0; i < NEED_COUNT; i++) delta[i] = 0;

    if (dead) begin
      mood_d = mood_q;
    end else if (test) begin
      care_idx = sel_for_mood(test_mood_q);
      if (b_rise) levels_d[care_idx] = levels_q[care_idx] + 3'd1;
      if (a_rise) test_mood_d = next_forced_mood(test_mood_q);
      sel_d  = sel_for_mood(test_mood_d);
      mood_d = test_mood_d;
    end else begin
      test_mood_d = MOOD_IDLE;
      if (tick) begin
        phase_d = !phase_q;
        if (sleep_q) begin
          delta[ENERGY] = delta[ENERGY] + 1;
          if (phase_q) delta[HUNGER] = delta[HUNGER] - 1;
        end else begin
          delta[HUNGER] = delta[HUNGER] - 1;
          delta[FUN]    = delta[FUN] - 1;
          if (phase_q) delta[ENERGY] = delta[ENERGY] - 1;
        end
        if (levels_q[HUNGER] == 3'd0 || levels_q[ENERGY] == 3'd0 || levels_q[FUN] == 3'd0)
          delta[HEALTH] = delta[HEALTH] - 1;
      end
      if (b_rise && !sleep_q) delta[care_idx] = delta[care_idx] + CARE_STEP;
      for (int i = 0; i < NEED_COUNT; i++)
        levels_d[i] = clamp_level(int'(levels_q[i]) + delta[i]);
      if (a_rise) sel_d = sel_q + 2'd1;
      if (c_rise) sleep_d = !sleep_q;
      mood_d = mood_from_levels(levels_d);
`ifdef FSM_MASCOTA_DEATH_EN
      if (levels_d[HEALTH] == 3'd0) mood_d = MOOD_DEAD;
`endif
    end
  end

  always_comb begin
    selected_level = (mood_d == MOOD_DEAD) ? 3'd0 : levels_d[sel_d];
    for (int i = 0; i < NEED_COUNT; i++) alerts_d[i] = (levels_d[i] <= LEVEL_ALERT);
  end

  // Outputs are registered from the same next-state values as the state, so
  // every effect shows right after the edge that caused it.
  always_ff @(posedge clk) begin
    if (reset) begin
      levels_q    <= {NEED_COUNT{LEVEL_RESET}};
      sel_q       <= HUNGER;
      sleep_q     <= 1'b0;
      mood_q      <= MOOD_IDLE;
      test_mood_q <= MOOD_IDLE;
      phase_q     <= 1'b0;
      color_q     <= 2'b00;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      output1     <= {MOOD_IDLE, LEVEL_RESET, 2'b00};
      output2     <= 4'h0;
    end else begin
      levels_q    <= levels_d;
      sel_q       <= sel_d;
      sleep_q     <= sleep_d;
      mood_q      <= mood_d;
      test_mood_q <= test_mood_d;
      phase_q     <= phase_d;
      color_q     <= color;
      a_q         <= A;
      b_q         <= B;
      c_q         <= C;
      output1     <= {mood_d, selected_level, color};
      output2     <= alerts_d;
    end
  end

endmodule

// File: tb/tb_fsm_mascota.sv
// Self-checking bench for fsm_mascota: vector table, hand-written corner sequences
// and a randomized run against a plain-arithmetic pet model.
module tb_fsm_mascota;

  localparam int BASE_TICK = 16;
  localparam int CARE_STEP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_btn = 1'b0, b_btn = 1'b0, c_btn = 1'b0, test_mode = 1'b0;
  logic [1:0] color = 2'b00, time_control = 2'b00;
  logic [7:0] output1;
  logic [3:0] output2;

  int check_count = 0;
  int pass_count  = 0;

  fsm_mascota #(.BASE_TICK(BASE_TICK), .CARE_STEP(CARE_STEP)) dut (
    .clk          (clk),
    .reset        (reset),
    .A            (a_btn),
    .B            (b_btn),
    .C            (c_btn),
    .test         (test_mode),
    .color        (color),
    .time_control (time_control),
    .output1      (output1),
    .output2      (output2)
  );

  always #5 clk = ~clk;

  // Reference pet: levels as ints, moods as their numeric codes.
  int m_lv [4];
  int m_sel, m_mood, m_tmood, m_col, m_cnt, m_ptc, m_ticks;
  bit m_sleep, m_pa, m_pb, m_pc;
  int sel_tab [5] = '{0, 0, 1, 2, 3};

  function automatic int clamp7(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic int mood_of(input int h, input int e, input int f, input int hl);
    if (hl <= 1) return 4;
    if (h <= 1) return 1;
    if (e <= 1) return 2;
    if (f <= 1) return 3;
    return 0;
  endfunction

  task automatic model_step();
    bit ra, rb, rc, tk, is_dead;
    int period;
    int nl [4];
    if (reset) begin
      for (int i = 0; i < 4; i++) m_lv[i] = 7;
      m_sel = 0; m_mood = 0; m_tmood = 0; m_col = 0; m_cnt = 0; m_ticks = 0;
      m_sleep = 0; m_pa = 0; m_pb = 0; m_pc = 0;
      m_ptc = int'(time_control);
    end else begin
      ra = a_btn && !m_pa;
      rb = b_btn && !m_pb;
      rc = c_btn && !m_pc;
      is_dead = (m_mood == 5);
      period = BASE_TICK * (1 << (2 * int'(time_control)));
      tk = 0;
      if (int'(time_control) != m_ptc) m_cnt = 0;
      else if (!(test_mode || is_dead)) begin
        if (m_cnt == period - 1) begin tk = 1; m_cnt = 0; end
        else m_cnt++;
      end
      m_ptc = int'(time_control);
      if (!is_dead) begin
        if (test_mode) begin
          if (rb) m_lv[sel_tab[m_tmood]] = (m_lv[sel_tab[m_tmood]] + 1) % 8;
          if (ra) m_tmood = (m_tmood + 1) % 5;
          m_sel = sel_tab[m_tmood];
          m_mood = m_tmood;
        end else begin
          m_tmood = 0;
          for (int i = 0; i < 4; i++) nl[i] = m_lv[i];
          if (tk) begin
            m_ticks++;
            if (m_sleep) begin
              nl[1] += 1;
              if (m_ticks % 2 == 0) nl[0] -= 1;
            end else begin
              nl[0] -= 1;
              nl[2] -= 1;
              if (m_ticks % 2 == 0) nl[1] -= 1;
            end
            if (m_lv[0] == 0 || m_lv[1] == 0 || m_lv[2] == 0) nl[3] -= 1;
          end
          if (rb && !m_sleep) nl[m_sel] += CARE_STEP;
          for (int i = 0; i < 4; i++) m_lv[i] = clamp7(nl[i]);
          if (ra) m_sel = (m_sel + 1) % 4;
          if (rc) m_sleep = !m_sleep;
          m_mood = mood_of(m_lv[0], m_lv[1], m_lv[2], m_lv[3]);
`ifdef FSM_MASCOTA_DEATH_EN
          if (m_lv[3] == 0) m_mood = 5;
`endif
        end
      end
      m_pa = a_btn; m_pb = b_btn; m_pc = c_btn;
      m_col = int'(color);
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [7:0] model_o1();
    int shown;
    shown = (m_mood == 5) ? 0 : m_lv[m_sel];
    return 8'((m_mood << 5) | (shown << 2) | m_col);
  endfunction

  function automatic logic [3:0] model_o2();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_lv[i] <= 1);
    return r;
  endfunction

  task automatic applyStimulus(input bit rst, input bit a, input bit b, input bit c,
                               input bit t, input logic [1:0] col, input logic [1:0] tc);
    reset = rst; a_btn = a; b_btn = b; c_btn = c; test_mode = t;
    color = col; time_control = tc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input bit t);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, t, 2'b00, 2'b00);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp1, input logic [3:0] exp2);
    check_count++;
    if (output1 === exp1 && output2 === exp2) pass_count++;
    else $display("[TB] FAIL %s: output1=%h output2=%b, expected output1=%h output2=%b",
                  name, output1, output2, exp1, exp2);
  endtask

  typedef struct {
    bit         rst, a, b, c, t;
    logic [1:0] col;
    logic [7:0] o1;
    logic [3:0] o2;
  } vec_t;

  vec_t vecs [17];
  logic [7:0] exp_dead_o1, exp_dead_a_o1;

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 2'b00, 8'h1C, 4'h0};
    vecs[1]  = '{0, 0, 0, 0, 0, 2'b10, 8'h1E, 4'h0};
    vecs[2]  = '{0, 0, 0, 0, 1, 2'b00, 8'h1C, 4'h0};
    vecs[3]  = '{0, 1, 0, 0, 1, 2'b00, 8'h3C, 4'h0};
    vecs[4]  = '{0, 0, 0, 0, 1, 2'b00, 8'h3C, 4'h0};
    vecs[5]  = '{0, 0, 1, 0, 1, 2'b00, 8'h20, 4'h1};
    vecs[6]  = '{0, 0, 1, 0, 1, 2'b00, 8'h20, 4'h1};
    vecs[7]  = '{0, 0, 0, 0, 1, 2'b00, 8'h20, 4'h1};
    vecs[8]  = '{0, 0, 1, 0, 1, 2'b00, 8'h24, 4'h1};
    vecs[9]  = '{0, 0, 0, 0, 1, 2'b00, 8'h24, 4'h1};
    vecs[10] = '{0, 0, 1, 0, 1, 2'b00, 8'h28, 4'h0};
    vecs[11] = '{0, 1, 0, 0, 1, 2'b00, 8'h5C, 4'h0};
    vecs[12] = '{0, 0, 1, 0, 1, 2'b00, 8'h40, 4'h2};
    vecs[13] = '{0, 0, 0, 0, 0, 2'b00, 8'h40, 4'h2};
    vecs[14] = '{0, 0, 1, 0, 0, 2'b00, 8'h08, 4'h0};
    vecs[15] = '{0, 0, 0, 1, 0, 2'b00, 8'h08, 4'h0};
    vecs[16] = '{0, 0, 1, 1, 0, 2'b00, 8'h08, 4'h0};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].t, vecs[i].col, 2'b00);
      checkOutput($sformatf("vector_%0d", i), vecs[i].o1, vecs[i].o2);
    end

    // Forced mood wraps after five presses; test mode never decays.
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 2'b00, 2'b00);
      applyStimulus(0, 0, 0, 0, 1, 2'b00, 2'b00);
    end
    checkOutput("test_mood_wrap", 8'h1C, 4'h0);
    idleCycles(300, 1);
    checkOutput("test_no_decay", 8'h1C, 4'h0);

    // Decay timing at the shortest period.
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(16, 0);
    checkOutput("first_tick_hunger6", 8'h18, 4'h0);
    applyStimulus(0, 1, 0, 0, 0, 2'b00, 2'b00);
    checkOutput("select_energy7", 8'h1C, 4'h0);
    idleCycles(15, 0);
    checkOutput("second_tick_energy6", 8'h18, 4'h0);

    // Drain hunger to zero, then one care action even with B held.
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(112, 0);
    checkOutput("hunger_drained", 8'h20, 4'b0101);
    applyStimulus(0, 0, 1, 0, 0, 2'b00, 2'b00);
    checkOutput("care_hunger2", 8'h68, 4'b0100);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, 0, 2'b00, 2'b00);
    checkOutput("held_b_once", 8'h68, 4'b0100);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b00);

    // Health to zero, then back to normal mode.
`ifdef FSM_MASCOTA_DEATH_EN
    exp_dead_o1 = 8'hA0; exp_dead_a_o1 = 8'hA0;
`else
    exp_dead_o1 = 8'h80; exp_dead_a_o1 = 8'h9C;
`endif
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 2'b00, 2'b00);
      applyStimulus(0, 0, 0, 0, 1, 2'b00, 2'b00);
    end
    checkOutput("forced_sick", 8'h9C, 4'h0);
    applyStimulus(0, 0, 1, 0, 1, 2'b00, 2'b00);
    checkOutput("health_wrap0", 8'h80, 4'b1000);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 2'b00);
    checkOutput("health0_normal", exp_dead_o1, 4'b1000);
    applyStimulus(0, 1, 0, 0, 0, 2'b00, 2'b00);
    checkOutput("health0_button", exp_dead_a_o1, 4'b1000);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
    checkOutput("reset_after_health0", 8'h1C, 4'h0);

    // Randomized run against the reference model.
    begin
      bit t_r;
      logic [1:0] tc_r;
      t_r = 0; tc_r = 2'b00;
      applyStimulus(1, 0, 0, 0, 0, 2'b00, 2'b00);
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 199) == 0) t_r = !t_r;
        if ($urandom_range(0, 399) == 0) tc_r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        applyStimulus(($urandom_range(0, 699) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                      t_r, 2'($urandom_range(0, 3)), tc_r);
        checkOutput("random", model_o1(), model_o2());
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
